// File: rtl/riscv_state_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
// The 2-bit counter encodings and their saturating update live here so the BU and the table agree.
package riscv_state_pkg;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] pred, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (pred == BP_ST) ? BP_ST : pred + 2'b01;
        end else begin
            res = (pred == BP_SNT) ? BP_SNT : pred - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// 1R1W synchronous RAM for the prediction counters. Read is registered and gated by re;
// a same-address read and write returns the old contents (callers bypass if they need new data).
module riscv_bp_ram #(
    parameter int ABITS = 12,
    parameter int DBITS = 2
) (
    input  logic             clk,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata
);

    logic [DBITS-1:0] mem_q [2**ABITS];
    logic [DBITS-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port, holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_bp.sv
// gshare branch prediction table: 2-bit counters indexed by {global history, PC bits}.
// Sweeps the table to weakly-not-taken after reset, then serves 1-cycle reads and BU updates.
module riscv_bp
    import riscv_state_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 0
) (
    input  logic                      rstn,
    input  logic                      clk,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_nxt_pc,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_init_busy,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic                      bu_bp_update,
    input  logic                      bu_bp_btaken,
    input  logic [1:0]                bu_bp_predict,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history
);

    localparam int IDX   = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 2 ** IDX;
    localparam int PC_LO = (HAS_RVC != 0) ? 1 : 2;

    bp_state_t      state_q, state_d;
    logic [IDX-1:0] init_cnt_q, init_cnt_d;
    logic           busy_q, busy_d;
    logic           rd_ok_q, rd_ok_d;
    logic           byp_q, byp_d;
    logic [1:0]     byp_val_q, byp_val_d;

    logic [IDX-1:0] rd_idx_s, wr_idx_s, ram_waddr_s;
    logic [1:0]     nxt_cnt_s, ram_wdata_s, ram_rdata_s;
    logic           ram_we_s, ram_re_s;
    logic           unused_pc_s;

    assign rd_idx_s    = {bu_bp_history, if_nxt_pc[PC_LO +: BP_LOCAL_BITS]};
    assign wr_idx_s    = {bu_bp_history, ex_pc[PC_LO +: BP_LOCAL_BITS]};
    assign nxt_cnt_s   = sat_update(bu_bp_predict, bu_bp_btaken);
    assign ram_re_s    = ~if_stall;
    assign unused_pc_s = ^{if_nxt_pc, ex_pc};

    // Write port mux: init sweep owns the port until RUN, BU updates are dropped meanwhile
    always_comb begin
        if (state_q == BP_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = init_cnt_q;
            ram_wdata_s = BP_WNT;
        end else begin
            ram_we_s    = bu_bp_update;
            ram_waddr_s = wr_idx_s;
            ram_wdata_s = nxt_cnt_s;
        end
    end

    // Next-state for the init/run FSM and sweep counter
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            BP_INIT: begin
                init_cnt_d = init_cnt_q + IDX'(1'b1);
                if (init_cnt_q == IDX'(DEPTH - 1)) begin
                    state_d = BP_RUN;
                end else begin
                    state_d = BP_INIT;
                end
            end
            BP_RUN: begin
                state_d = BP_RUN;
            end
            default: begin
                state_d    = BP_INIT;
                init_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == BP_INIT);
    end

    // Read-side control: collision bypass and validity are captured only on non-stalled edges
    always_comb begin
        rd_ok_d   = rd_ok_q;
        byp_d     = byp_q;
        byp_val_d = byp_val_q;
        if (!if_stall) begin
            // a read launched on the edge entering RUN already counts as a real prediction
            rd_ok_d   = (state_d == BP_RUN);
            byp_d     = ram_we_s && (ram_waddr_s == rd_idx_s);
            byp_val_d = ram_wdata_s;
        end else begin
            rd_ok_d   = rd_ok_q;
            byp_d     = byp_q;
            byp_val_d = byp_val_q;
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BP_INIT;
            init_cnt_q <= '0;
            busy_q     <= 1'b1;
            rd_ok_q    <= 1'b0;
            byp_q      <= 1'b0;
            byp_val_q  <= BP_SNT;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_q     <= busy_d;
            rd_ok_q    <= rd_ok_d;
            byp_q      <= byp_d;
            byp_val_q  <= byp_val_d;
        end
    end

    riscv_bp_ram #(
        .ABITS (IDX),
        .DBITS (2)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re_s),
        .raddr (rd_idx_s),
        .rdata (ram_rdata_s),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s)
    );

    assign bp_bp_predict = !rd_ok_q ? BP_SNT : (byp_q ? byp_val_q : ram_rdata_s);
    assign bp_init_busy  = busy_q;

endmodule

// File: tb/tb_riscv_bp.sv
// Directed bench for riscv_bp: stimulus pushes expected predictions into a scoreboard queue,
// a negedge monitor pops and compares them against bp_bp_predict when they fall due.
module tb_riscv_bp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_stall;
    logic [31:0] if_nxt_pc;
    logic [31:0] ex_pc;
    logic        bu_bp_update;
    logic        bu_bp_btaken;
    logic [1:0]  bu_bp_predict;
    logic [1:0]  bu_bp_history;
    logic [1:0]  bp_bp_predict;
    logic        bp_init_busy;

    riscv_bp #(
        .XLEN           (32),
        .BP_GLOBAL_BITS (2),
        .BP_LOCAL_BITS  (10),
        .HAS_RVC        (0)
    ) dut (
        .rstn          (rstn),
        .clk           (clk),
        .if_stall      (if_stall),
        .if_nxt_pc     (if_nxt_pc),
        .bp_bp_predict (bp_bp_predict),
        .bp_init_busy  (bp_init_busy),
        .ex_pc         (ex_pc),
        .bu_bp_update  (bu_bp_update),
        .bu_bp_btaken  (bu_bp_btaken),
        .bu_bp_predict (bu_bp_predict),
        .bu_bp_history (bu_bp_history)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] exp;
        int         due;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: compare every scoreboard entry whose cycle has arrived
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk(e.name, int'(bp_bp_predict), int'(e.exp));
        end
    end

    task automatic expect_next(input logic [1:0] e, input string n);
        exp_t it;
        it.exp  = e;
        it.due  = cyc + 1;
        it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic rd(input logic [31:0] pc, input logic [1:0] h, input logic [1:0] e, input string n);
        if_nxt_pc     = pc;
        bu_bp_history = h;
        if_stall      = 1'b0;
        expect_next(e, n);
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] h, input logic t, input logic [1:0] p);
        ex_pc         = pc;
        bu_bp_history = h;
        bu_bp_btaken  = t;
        bu_bp_predict = p;
        bu_bp_update  = 1'b1;
        if_stall      = 1'b0;
        if_nxt_pc     = 32'h0000_0FF0;
        @(negedge clk);
        bu_bp_update  = 1'b0;
    endtask

    // Count cycles of bp_init_busy after reset release; optionally inject an update at cycle upd_at
    task automatic init_sweep(input string n, input int upd_at);
        int cnt  = 0;
        int nz   = 0;
        bit done = 1'b0;
        if_nxt_pc     = 32'h0000_0200;
        bu_bp_history = 2'b00;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            bu_bp_update = 1'b0;
            if (bp_init_busy) begin
                if (bp_bp_predict != 2'b00) nz = 1;
                if (cnt == upd_at) begin
                    ex_pc         = 32'h0000_0200;
                    bu_bp_btaken  = 1'b1;
                    bu_bp_predict = 2'b10;
                    bu_bp_update  = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk(n, cnt, 4096);
        chk({n, "_pred_zero"}, nz, 0);
        bu_bp_update = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn          = 1'b0;
        if_stall      = 1'b0;
        if_nxt_pc     = 32'h0000_0200;
        ex_pc         = 32'h0;
        bu_bp_update  = 1'b0;
        bu_bp_btaken  = 1'b0;
        bu_bp_predict = 2'b00;
        bu_bp_history = 2'b00;

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bp_init_busy), 1);
        chk("reset_pred", int'(bp_bp_predict), 0);
        rstn = 1'b1;
        init_sweep("init_len", -1);

        rd(32'h0000_0200, 2'b00, 2'b01, "post_init_read");
        upd(32'h0000_0200, 2'b00, 1'b1, 2'b01);
        rd(32'h0000_0200, 2'b00, 2'b10, "train_h00");
        rd(32'h0000_0200, 2'b01, 2'b01, "train_h01");
        rd(32'hABCD_F200, 2'b00, 2'b10, "upper_pc_ignored");
        upd(32'h0000_0240, 2'b00, 1'b1, 2'b11);
        rd(32'h0000_0240, 2'b00, 2'b11, "sat_high");
        upd(32'h0000_0280, 2'b00, 1'b0, 2'b00);
        rd(32'h0000_0280, 2'b00, 2'b00, "sat_low");
        upd(32'h0000_02C0, 2'b00, 1'b0, 2'b10);
        rd(32'h0000_02C0, 2'b00, 2'b01, "decrement");

        // Collision: write and read the same entry on one edge
        ex_pc         = 32'h0000_0300;
        if_nxt_pc     = 32'h0000_0300;
        bu_bp_history = 2'b10;
        bu_bp_btaken  = 1'b1;
        bu_bp_predict = 2'b10;
        bu_bp_update  = 1'b1;
        if_stall      = 1'b0;
        expect_next(2'b11, "collision");
        @(negedge clk);
        bu_bp_update = 1'b0;
        rd(32'h0000_0300, 2'b10, 2'b11, "post_collision");

        // Stall: output held for 3 cycles while an update lands on the held entry
        rd(32'h0000_0200, 2'b00, 2'b10, "pre_stall");
        for (int i = 0; i < 3; i++) begin
            if_stall      = 1'b1;
            if_nxt_pc     = 32'h0000_0240 + 32'(i) * 32'h40;
            bu_bp_history = 2'b00;
            if (i == 1) begin
                ex_pc         = 32'h0000_0200;
                bu_bp_btaken  = 1'b1;
                bu_bp_predict = 2'b10;
                bu_bp_update  = 1'b1;
            end else begin
                bu_bp_update  = 1'b0;
            end
            expect_next(2'b10, "stall_hold");
            @(negedge clk);
        end
        bu_bp_update = 1'b0;
        rd(32'h0000_0200, 2'b00, 2'b11, "stall_release");

        // Reset in the middle of INIT restarts the sweep
        rstn = 1'b0;
        #1;
        chk("rst2_busy", int'(bp_init_busy), 1);
        chk("rst2_pred", int'(bp_bp_predict), 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            bu_bp_update = (i == 50);
        end
        bu_bp_update = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midinit_busy", int'(bp_init_busy), 1);
        chk("midinit_pred", int'(bp_bp_predict), 0);
        @(negedge clk);
        rstn = 1'b1;
        init_sweep("midinit_len", 3000);
        rd(32'h0000_0200, 2'b00, 2'b01, "init_upd_dropped");
        rd(32'h0000_0240, 2'b00, 2'b01, "midinit_reswept");

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
